mem_access_unit: RTL

- Load/store unit directly downstream of the pipeline core's memory stage.
- Consumes the M-stage access (opM, MemReadM, MemWriteM, EXResultM, WriteDataM) and runs it as a req/ack transaction on an external data bus.
- Returns the formatted ReadDataM and stalls the core until the access completes.
- Performs byte-lane steering, sign/zero extension and bus timeout detection.

---
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ack data-bus bundle between the load/store unit
// (master) and the memory system (slave).
//   bus_req   master->slave  request, held until ack or abort
//   bus_we    master->slave  1 = write
//   bus_addr  master->slave  word-aligned byte address (ADDR_W bits)
//   bus_wstrb master->slave  byte write enables
//   bus_wdata master->slave  lane-steered store data
//   bus_ack   slave->master  completion, only meaningful while bus_req=1
//   bus_rdata slave->master  read word, sampled on the ack cycle
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_wstrb;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit behind the core's M stage. Runs each
// M-stage access as one req/ack bus transaction, stalls the core until it
// completes, steers store bytes, formats load data, aborts on bus timeout.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   opM             M-stage opcode (LB/LH/LW/LBU/LHU/SB/SH/SW, else word)
//   MemReadM/WriteM access request (write wins when both set)
//   EXResultM       byte address; WriteDataM store data
//   ReadDataM       formatted load result, held until the next capture
//   mem_stall       holds F/D/E/M; bus_err one-cycle timeout pulse
//   bus             mem_access_unit_if.master data bus
// Optional: define MEM_ADDR_EXC_EN to add adel/ades misaligned-access
// exception outputs; otherwise misaligned addresses are aligned down.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] EXResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        mem_stall,
  output logic        bus_err,
`ifdef MEM_ADDR_EXC_EN
  output logic        adel,
  output logic        ades,
`endif
  mem_access_unit_if.master bus
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           r_state, w_state_n;
  logic [5:0]       r_op;
  logic [1:0]       r_lo;
  logic [CNT_W-1:0] r_cnt;

  logic        w_access, w_we, w_sb, w_sh, w_stall, w_start, w_to_hit;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_addr_al, w_fmt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
`ifdef MEM_ADDR_EXC_EN
  logic w_misal, w_exc, w_is_half, w_is_word;
`endif

  assign w_access  = MemReadM | MemWriteM;
  assign w_we      = MemWriteM;
  assign w_sb      = w_we && (opM == OP_SB);
  assign w_sh      = w_we && (opM == OP_SH);
  assign w_addr_al = {EXResultM[31:2], 2'b00};

  // Store lane steering; loads never assert strobes.
  always_comb begin
    w_wstrb = '0;
    w_wdata = WriteDataM;
    if (w_sb) begin
      w_wstrb = 4'b0001 << EXResultM[1:0];
      w_wdata = {4{WriteDataM[7:0]}};
    end else if (w_sh) begin
      w_wstrb = EXResultM[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{WriteDataM[15:0]}};
    end else if (w_we) begin
      w_wstrb = '1;
    end
  end

`ifdef MEM_ADDR_EXC_EN
  // Access size depends on direction: a store-only opcode on a load is a word.
  assign w_is_half = w_we ? w_sh : ((opM == OP_LH) || (opM == OP_LHU));
  assign w_is_word = w_we ? !(w_sb || w_sh)
                          : !((opM == OP_LB) || (opM == OP_LBU) ||
                              (opM == OP_LH) || (opM == OP_LHU));
  assign w_misal   = (w_is_half && EXResultM[0]) ||
                     (w_is_word && (EXResultM[1:0] != 2'b00));
`endif

  // Load formatting from the latched opcode/low address bits.
  always_comb begin
    unique case (r_lo)
      2'd0:    w_byte = bus.bus_rdata[7:0];
      2'd1:    w_byte = bus.bus_rdata[15:8];
      2'd2:    w_byte = bus.bus_rdata[23:16];
      default: w_byte = bus.bus_rdata[31:24];
    endcase
    w_half = r_lo[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    unique case (r_op)
      OP_LB:   w_fmt = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_fmt = {24'h0, w_byte};
      OP_LH:   w_fmt = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_fmt = {16'h0, w_half};
      default: w_fmt = bus.bus_rdata;
    endcase
  end

  assign w_to_hit = (TIMEOUT != 0) && (32'(r_cnt) == TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_stall   = 1'b0;
    w_start   = 1'b0;
`ifdef MEM_ADDR_EXC_EN
    w_exc     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_access) begin
`ifdef MEM_ADDR_EXC_EN
          if (w_misal) w_exc = 1'b1;
          else
`endif
          begin
            w_start   = 1'b1;
            w_stall   = 1'b1;
            w_state_n = REQ;
          end
        end
      end
      REQ: begin
        w_stall = 1'b1;
        if (bus.bus_ack || w_to_hit) w_state_n = DONE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign mem_stall   = w_stall & rst;
  assign bus.bus_req = (r_state == REQ);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ReadDataM     <= '0;
      bus_err       <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wstrb <= '0;
      bus.bus_wdata <= '0;
      r_op          <= '0;
      r_lo          <= '0;
      r_cnt         <= '0;
`ifdef MEM_ADDR_EXC_EN
      adel          <= 1'b0;
      ades          <= 1'b0;
`endif
    end else begin
      bus_err <= 1'b0;
`ifdef MEM_ADDR_EXC_EN
      adel    <= 1'b0;
      ades    <= 1'b0;
      if (w_exc) begin
        adel      <= !w_we;
        ades      <= w_we;
        ReadDataM <= '0;
      end
`endif
      if (w_start) begin
        bus.bus_we    <= w_we;
        bus.bus_addr  <= ADDR_W'(w_addr_al);
        bus.bus_wstrb <= w_wstrb;
        bus.bus_wdata <= w_wdata;
        r_op          <= opM;
        r_lo          <= EXResultM[1:0];
      end
      if (r_state == REQ) begin
        if (bus.bus_ack) begin
          ReadDataM <= w_fmt;
          r_cnt     <= '0;
        end else if (w_to_hit) begin
          ReadDataM <= '0;
          bus_err   <= 1'b1;
          r_cnt     <= '0;
        end else begin
          r_cnt     <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule
